// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point classes, flag indices, rounding modes and bias helper.
package fp_pkg;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;
  localparam int FLAG_INVALID = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT = 0;
  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalise, round, pack and raise exceptions for a raw mantissa product.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   sign,
  input  logic [1:0]             cls_a,
  input  logic [1:0]             cls_b,
  input  logic [EXP_W+1:0]       exp,
  input  logic [2*MAN_W+1:0]     prod,
  input  logic                   rnd,
  output logic [EXP_W+MAN_W:0]   res,
  output logic [3:0]             flags
);
  localparam int P = 2 * MAN_W + 2;
  logic msb, guard, sticky, inc, carry, ovf, udf, nan, inf, zero, fin;
  logic [P-2:0] n;
  logic [MAN_W-1:0] frac;
  logic [EXP_W+1:0] exp_f;
  always_comb begin
    msb = prod[P-1];
    n = msb ? prod[P-2:0] : {prod[P-3:0], 1'b0};
    guard = n[MAN_W];
    sticky = |n[MAN_W-1:0];
    inc = (rnd == RND_RNE) & guard & (sticky | n[MAN_W+1]);
    {carry, frac} = {1'b0, n[P-2:MAN_W+1]} + (MAN_W+1)'(inc);
    exp_f = exp + (EXP_W+2)'(msb) + (EXP_W+2)'(carry);
    // exp_f is two's complement: top bit set means negative
    ovf = ~exp_f[EXP_W+1] & (exp_f[EXP_W] | &exp_f[EXP_W-1:0]);
    udf = exp_f[EXP_W+1] | ~|exp_f;
    nan = cls_a == NAN || cls_b == NAN || (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF);
    inf = cls_a == INF || cls_b == INF;
    zero = cls_a == ZERO || cls_b == ZERO;
    fin = ~nan & ~inf & ~zero;
    res = nan  ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
          inf  ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
          zero ? {sign, {(EXP_W+MAN_W){1'b0}}} :
          ovf  ? (rnd ? {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}} : {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}) :
          udf  ? {sign, {(EXP_W+MAN_W){1'b0}}} :
                 {sign, exp_f[EXP_W-1:0], frac};
    flags = '0;
    flags[FLAG_INVALID] = nan;
    flags[FLAG_OVERFLOW] = fin & ovf;
    flags[FLAG_UNDERFLOW] = fin & udf;
    flags[FLAG_INEXACT] = fin & (ovf | udf | guard | sticky);
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier with valid/ready backpressure.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'(fp_bias(EXP_W));
  function automatic fp_class_t classify(input logic [W-2:0] v);
    return (v[W-2:MAN_W] == '0) ? ZERO : (&v[W-2:MAN_W]) ? ((|v[MAN_W-1:0]) ? NAN : INF) : NORMAL;
  endfunction
  logic en, v1, s1, rm1, v2, s2, rm2;
  fp_class_t ca1, cb1, ca2, cb2;
  logic [EXP_W+1:0] e1, e2;
  logic [MAN_W:0] ma1, mb1;
  logic [2*MAN_W+1:0] p2;
  logic [W-1:0] rp_res;
  logic [3:0] rp_flags;
  // whole pipeline freezes, bubbles included, while the output is blocked
  assign en = ~(out_valid & ~out_ready);
  assign in_ready = en;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      flags <= '0;
    end else if (en) begin
      v1 <= in_valid;
      s1 <= a[W-1] ^ b[W-1];
      ca1 <= classify(a[W-2:0]);
      cb1 <= classify(b[W-2:0]);
      e1 <= {2'b00, a[W-2:MAN_W]} + {2'b00, b[W-2:MAN_W]} - BIAS;
      ma1 <= {1'b1, a[MAN_W-1:0]};
      mb1 <= {1'b1, b[MAN_W-1:0]};
      rm1 <= rnd_mode;
      v2 <= v1;
      s2 <= s1;
      ca2 <= ca1;
      cb2 <= cb1;
      e2 <= e1;
      p2 <= (2*MAN_W+2)'(ma1) * (2*MAN_W+2)'(mb1);
      rm2 <= rm1;
      out_valid <= v2;
      result <= rp_res;
      flags <= rp_flags;
    end
  end
  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign(s2),
    .cls_a(ca2),
    .cls_b(cb2),
    .exp(e2),
    .prod(p2),
    .rnd(rm2),
    .res(rp_res),
    .flags(rp_flags)
  );
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed, backpressure, reset and random checks of fp_mul_pipe against a real-arithmetic model.
module tb_fp_mul_pipe;
  logic clk = 1'b0, rst_n, in_valid, in_ready, rnd_mode, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0] flags;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [35:0] exp_q[$];
  int cyc_q[$];
  logic held = 1'b0, lat_chk = 1'b0, acc;
  logic [36:0] held_val;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    for (int i = 0; i < (k < 0 ? -k : k); i++) r = (k < 0) ? r / 2.0 : r * 2.0;
    return r;
  endfunction

  // exact product in real arithmetic, then rounded to single precision by value
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic rm);
    logic s, zx, zy, ix, iy, nx, ny, inex;
    real m, sc, ip, rem;
    longint mant;
    int k, be;
    s = x[31] ^ y[31];
    zx = x[30:23] == 8'h00;
    zy = y[30:23] == 8'h00;
    ix = x[30:23] == 8'hFF && x[22:0] == 0;
    iy = y[30:23] == 8'hFF && y[22:0] == 0;
    nx = x[30:23] == 8'hFF && x[22:0] != 0;
    ny = y[30:23] == 8'hFF && y[22:0] != 0;
    if (nx || ny || (ix && zy) || (iy && zx)) return {4'b1000, 32'h7FC00000};
    if (ix || iy) return {4'b0000, s, 8'hFF, 23'h0};
    if (zx || zy) return {4'b0000, s, 31'h0};
    m = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127) *
        (1.0 + real'(y[22:0]) / 8388608.0) * pow2(int'(y[30:23]) - 127);
    k = 0;
    while (m >= pow2(k + 1)) k++;
    while (m < pow2(k)) k--;
    sc = m * pow2(23 - k);
    ip = $floor(sc);
    rem = sc - ip;
    mant = longint'(ip);
    if (!rm && (rem > 0.5 || (rem == 0.5 && mant[0]))) mant++;
    if (mant == 64'd16777216) begin
      mant = 64'd8388608;
      k++;
    end
    be = k + 127;
    inex = rem != 0.0;
    if (be >= 255) return rm ? {4'b0101, s, 8'hFE, 23'h7FFFFF} : {4'b0101, s, 8'hFF, 23'h0};
    if (be <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, inex, s, be[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int c = $urandom_range(0, 15);
    logic [7:0] e = (c == 0) ? 8'h00 : (c == 1) ? 8'hFF : 8'($urandom_range(1, 254));
    logic [22:0] f = (c == 1 && $urandom_range(0, 1) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib, input logic rm,
                      input logic ordy, input logic [35:0] e, output logic took);
    @(negedge clk);
    in_valid = iv;
    a = ia;
    b = ib;
    rnd_mode = rm;
    out_ready = ordy;
    #1;
    if (held) check("stable_while_stalled", {out_valid, flags, result}, held_val);
    if (out_valid && !out_ready) check("in_ready_during_stall", in_ready, 1'b0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("no_stale_result", out_valid, 1'b0);
      else begin
        check("result_flags", {flags, result}, exp_q.pop_front());
        if (lat_chk) check("latency", cyc - cyc_q[0], 3);
        void'(cyc_q.pop_front());
      end
    end
    took = in_valid && in_ready;
    if (took) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc);
    end
    held = out_valid && !out_ready;
    held_val = {out_valid, flags, result};
    cyc++;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 36'h0, acc);
      k++;
    end
    check("drain_complete", exp_q.size(), 0);
  endtask

  logic [31:0] d_a[9] = '{32'h40600000, 32'hC0600000, 32'h7F800000, 32'hFF800000, 32'h7F000000,
                          32'h7F000000, 32'h00800000, 32'h3F800001, 32'h3F800001};
  logic [31:0] d_b[9] = '{32'h40200000, 32'h40200000, 32'h00000000, 32'h40000000, 32'h7F000000,
                          32'h7F000000, 32'h3F000000, 32'h3F800001, 32'h3F800001};
  logic d_r[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [35:0] d_e[9] = '{{4'h0, 32'h410C0000}, {4'h0, 32'hC10C0000}, {4'h8, 32'h7FC00000},
                          {4'h0, 32'hFF800000}, {4'h5, 32'h7F800000}, {4'h5, 32'h7F7FFFFF},
                          {4'h3, 32'h00000000}, {4'h1, 32'h3F800002}, {4'h1, 32'h3F800002}};
  logic [31:0] bp_a[8], bp_b[8];
  logic bp_r[8];

  initial begin
    int i, c, idx;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_result", result, 32'h0);
    check("reset_flags", flags, 4'h0);
    rst_n = 1'b1;

    lat_chk = 1'b1;
    for (int j = 0; j < 9; j++) begin
      step(1'b1, d_a[j], d_b[j], d_r[j], 1'b1, d_e[j], acc);
      check("directed_accept", acc, 1'b1);
    end
    drain();

    lat_chk = 1'b0;
    for (int j = 0; j < 8; j++) begin
      bp_a[j] = rand_op();
      bp_b[j] = rand_op();
      bp_r[j] = 1'($urandom);
    end
    i = 0;
    c = 0;
    while ((i < 8 || exp_q.size() > 0) && c < 200) begin
      idx = (i < 8) ? i : 7;
      step(i < 8, bp_a[idx], bp_b[idx], bp_r[idx],
           (c >= 4 && c <= 8) ? 1'b0 : (c < 4) ? 1'b1 : ($urandom_range(0, 2) != 0),
           model(bp_a[idx], bp_b[idx], bp_r[idx]), acc);
      if (acc) i++;
      c++;
    end
    check("backpressure_all_delivered", (i == 8 && exp_q.size() == 0), 1'b1);
    held = 1'b0;

    for (int j = 0; j < 3; j++) step(1'b1, rand_op(), rand_op(), 1'b0, 1'b1, 36'h0, acc);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    held = 1'b0;
    cyc += 2;
    repeat (6) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 36'h0, acc);
    lat_chk = 1'b1;
    step(1'b1, 32'h40600000, 32'h40200000, 1'b0, 1'b1, {4'h0, 32'h410C0000}, acc);
    drain();

    lat_chk = 1'b0;
    i = 0;
    c = 0;
    while ((i < 150 || exp_q.size() > 0) && c < 2000) begin
      logic [31:0] ra, rb;
      logic rr;
      ra = rand_op();
      rb = rand_op();
      rr = 1'($urandom);
      step(i < 150 && $urandom_range(0, 4) != 0, ra, rb, rr, $urandom_range(0, 3) != 0, model(ra, rb, rr), acc);
      if (acc) i++;
      c++;
    end
    check("random_all_delivered", (i == 150 && exp_q.size() == 0), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point multiplier. It is the successor to the existing combinational single-precision multiply and is the multiply stage inside each processing element of the TPU MAC array.
- Generic exponent/mantissa widths.
- Valid/ready handshake with backpressure.
- Per-operation rounding mode.
- Full special-value handling and exception flags.
- Fixed 3-cycle latency at full throughput.

Parameters:
EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
MAN_W, 23, stored mantissa (fraction) width; operand/result width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
a  in  W  operand A {sign, exp, frac}
b  in  W  operand B
rnd_mode  in  1  0 = round-to-nearest-even (RNE), 1 = round-toward-zero (RTZ); sampled with operands
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  W  product
flags  out  4  {invalid, overflow, underflow, inexact}; qualified by out_valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: all stage valid bits 0, out_valid=0, result=0, flags=0. in_ready=1 out of reset.
- Reset mid-operation discards all in-flight items; out_valid=0 the cycle after reset is sampled low.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Pipeline stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational from registers and out_ready.
  - On stall every stage holds, including bubbles.
  - result/flags stay stable while out_valid & ~out_ready.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput 1/cycle. Results are returned in order.
- S1 (unpack):
  - Sign = sa^sb.
  - Classify each operand as zero, inf, NaN or normal. exp==0 counts as zero, so subnormal inputs flush to zero and keep their sign.
  - Biased exponent sum ea+eb-bias, held signed at EXP_W+2 bits.
  - Register mantissas with the hidden 1, and register rnd_mode.
- S2 (multiply): (MAN_W+1)x(MAN_W+1) unsigned product, 2*MAN_W+2 bits. Special-case class and exponent pass alongside.
- S3 (normalise, round, pack):
  - If product MSB is set: shift right 1 and exponent+1.
  - Guard bit = first dropped bit. Sticky = OR of the rest.
  - RNE: increment if guard & (sticky | lsb). RTZ: never increment.
  - If mantissa rounding carries out, exponent+1.
  - inexact = guard | sticky.
- Special results, in priority order:
  - Any NaN operand, or inf*zero: canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0). invalid=1.
  - inf*nonzero: inf with XOR sign. No flags.
  - zero*finite: zero with XOR sign. No flags.
- Overflow: final exponent >= 2^EXP_W-1. overflow=1, inexact=1.
  - RNE returns ±inf.
  - RTZ returns ±max finite (exp all ones minus 1, frac all ones).
- Underflow: final exponent <= 0. Result ±0, underflow=1, inexact=1 (flush to zero, no subnormal output).
- Simultaneous input and output transfers in the same cycle are legal and lose no data.

Decomposition:
- Shared package fp_pkg holds:
  - fp_class_t enum (ZERO, NORMAL, INF, NAN).
  - flag index constants FLAG_INVALID=3, FLAG_OVERFLOW=2, FLAG_UNDERFLOW=1, FLAG_INEXACT=0.
  - RND_RNE/RND_RTZ constants.
  - A function returning the bias for EXP_W.
- One sub-module: fp_round_pack, the combinational S3 normalise/round/pack/exception logic. It is reused later by the adder.

Test Plan:
- 0x40600000 (3.5) * 0x40200000 (2.5), RNE -> 0x410C0000, flags 0, out_valid exactly 3 cycles after transfer. 0xC0600000 * 0x40200000 -> 0xC10C0000.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, flags 4'b1000. 0xFF800000 * 0x40000000 -> 0xFF800000, flags 0.
- 0x7F000000 * 0x7F000000: RNE -> 0x7F800000, flags 4'b0101. RTZ -> 0x7F7FFFFF, flags 4'b0101.
- 0x00800000 * 0x3F000000 -> 0x00000000, flags 4'b0011. 0x3F800001 * 0x3F800001 (RNE or RTZ) -> 0x3F800002, flags 4'b0001.
- Backpressure:
  - Stimulus: stream 8 operand pairs back-to-back, out_ready=0 for cycles 4-8, then random out_ready.
  - Required: in_ready low whenever stall; all 8 results delivered in order and match a reference model; result stable while stalled.
- Reset mid-operation:
  - Stimulus: 3 items in flight, then rst_n=0 for one cycle.
  - Required: out_valid=0 the next cycle, no stale results afterwards; the first post-reset operation returns its correct result 3 cycles after transfer.
